full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Single-bit full adder. Combinational sum/carry outputs satisfy A+B+Ci = {Co,S}.
- Adds a clocked side-path:
  - one-cycle registered copy of the result, with a valid flag;
  - saturating counter of valid carry-out events.
- Leaf arithmetic cell used by switch/LED demo tops and ripple structures. The combinational path is the primary interface.

Parameters:
- CNT_W, default 8: width of the carry-event counter carry_cnt (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock for all registers
- rst  input  1  synchronous reset, active-high
- A  input  1  addend bit
- B  input  1  addend bit
- Ci  input  1  carry-in
- in_valid  input  1  qualifies A/B/Ci for the registered path and counter
- cnt_clr  input  1  synchronous clear of carry_cnt
- S  output  1  combinational sum = A ^ B ^ Ci
- Co  output  1  combinational carry = (A & B) | ((A ^ B) & Ci)
- S_r  output  1  registered sum
- Co_r  output  1  registered carry
- out_valid  output  1  S_r/Co_r hold a result captured from a valid input
- carry_cnt  output  CNT_W  count of valid cycles with Co=1, saturating

Behaviour:
- Combinational path:
  - S and Co depend only on A, B and Ci.
  - No dependence on clk, rst, in_valid or cnt_clr; zero latency.
  - Settles within one combinational delay of any input change.
  - No latches; X on any input may propagate X to S/Co.
- Truth table (A B Ci -> Co S):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Reset: on a rising clk edge with rst=1:
  - S_r=0, Co_r=0, out_valid=0, carry_cnt=0.
  - rst has priority over in_valid and cnt_clr.
  - S/Co are unaffected by reset.
- Registered path (rst=0), at each rising edge:
  - If in_valid=1: S_r<=S, Co_r<=Co, out_valid<=1.
  - If in_valid=0: S_r/Co_r hold their value, out_valid<=0.
  - Latency: one clock from valid input to out_valid.
  - Back-to-back valid inputs give back-to-back results; no stalls, no backpressure.
- Carry counter (rst=0):
  - Increments by 1 on edges where in_valid=1 and Co=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces 0 on that edge; clear beats increment when both occur.
- Reset mid-operation: a pending valid in the same cycle as rst is discarded; out_valid=0 on the next cycle.
- All registers are updated only on the rising clk edge; no asynchronous behaviour apart from the combinational S/Co.

Test Plan:
- Exhaustive combinational sweep, no clock needed: drive {A,B,Ci}=0..7 and check about 10 ns after each change -> S=0,1,1,0,1,0,0,1 and Co=0,0,0,1,0,1,1,1.
- Reset then registered result:
  - rst=1 for 2 cycles -> S_r=0, Co_r=0, out_valid=0, carry_cnt=0.
  - Then in_valid=1 with A=1, B=1, Ci=0 -> next cycle S_r=0, Co_r=1, out_valid=1, carry_cnt=1.
- Valid gating:
  - Apply A=B=Ci=1 with in_valid=0 -> S=1, Co=1 immediately; S_r/Co_r unchanged, out_valid=0, carry_cnt unchanged.
  - Raise in_valid -> next cycle S_r=1, Co_r=1.
- Saturation with CNT_W=2:
  - 5 consecutive valid cycles of A=B=1 -> carry_cnt 1, 2, 3, 3, 3.
  - cnt_clr=1 together with a valid carry -> carry_cnt=0.
- Reset priority: rst=1 with in_valid=1, Co=1 and cnt_clr=0 -> next cycle out_valid=0, carry_cnt=0, S_r=0, Co_r=0.

Source files
------------

// File: rtl/full_adder.sv
// Single-bit full adder with a combinational primary path, plus a clocked
// side-path: a registered copy of the result and a saturating carry-event counter.
module full_adder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             Ci,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             S,
    output logic             Co,
    output logic             S_r,
    output logic             Co_r,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_max;

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | ((A ^ B) & Ci);

    assign cnt_max = '1;
    assign cnt_sat = (carry_cnt == cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            S_r       <= 1'b0;
            Co_r      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S_r  <= S;
                Co_r <= Co;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (cnt_clr) begin
            carry_cnt <= '0;
        end else if (in_valid && Co && !cnt_sat) begin
            carry_cnt <= carry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a default-width instance and a 2-bit-counter
// instance share the same stimulus so saturation can be observed quickly.
module tb_full_adder;

    logic       clk;
    logic       rst;
    logic       A, B, Ci;
    logic       in_valid;
    logic       cnt_clr;

    logic       S, Co, S_r, Co_r, out_valid;
    logic [7:0] carry_cnt;
    logic       S2, Co2, S_r2, Co_r2, out_valid2;
    logic [1:0] carry_cnt2;

    int vectors;
    int miscompares;

    full_adder #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .S(S), .Co(Co), .S_r(S_r), .Co_r(Co_r),
        .out_valid(out_valid), .carry_cnt(carry_cnt)
    );

    full_adder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .S(S2), .Co(Co2), .S_r(S_r2), .Co_r(Co_r2),
        .out_valid(out_valid2), .carry_cnt(carry_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] s_tab;
        logic [7:0] co_tab;
        logic [1:0] sat_exp [5];
        vectors     = 0;
        miscompares = 0;
        s_tab       = 8'b1001_0110;
        co_tab      = 8'b1110_1000;
        sat_exp     = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; A = 1'b0; B = 1'b0; Ci = 1'b0;
        in_valid = 1'b0; cnt_clr = 1'b0;

        // Combinational truth-table sweep
        for (int v = 0; v < 8; v++) begin
            {A, B, Ci} = 3'(v);
            #10;
            check($sformatf("sweep_S_%0d", v), 32'(S), 32'(s_tab[v]));
            check($sformatf("sweep_Co_%0d", v), 32'(Co), 32'(co_tab[v]));
        end

        // Reset for two cycles
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; {A, B, Ci} = 3'b000;
        step();
        step();
        check("rst_S_r", 32'(S_r), 32'd0);
        check("rst_Co_r", 32'(Co_r), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_carry_cnt", 32'(carry_cnt), 32'd0);

        // First registered result: 1+1+0
        rst = 1'b0; in_valid = 1'b1; {A, B, Ci} = 3'b110;
        step();
        check("first_S_r", 32'(S_r), 32'd0);
        check("first_Co_r", 32'(Co_r), 32'd1);
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_carry_cnt", 32'(carry_cnt), 32'd1);

        // Valid gating: combinational path follows, registers do not
        in_valid = 1'b0; {A, B, Ci} = 3'b111;
        #1;
        check("gate_S", 32'(S), 32'd1);
        check("gate_Co", 32'(Co), 32'd1);
        step();
        check("gate_S_r_hold", 32'(S_r), 32'd0);
        check("gate_Co_r_hold", 32'(Co_r), 32'd1);
        check("gate_out_valid", 32'(out_valid), 32'd0);
        check("gate_carry_cnt", 32'(carry_cnt), 32'd1);

        in_valid = 1'b1;
        step();
        check("raise_S_r", 32'(S_r), 32'd1);
        check("raise_Co_r", 32'(Co_r), 32'd1);
        check("raise_out_valid", 32'(out_valid), 32'd1);
        check("raise_carry_cnt", 32'(carry_cnt), 32'd2);

        // Clear both counters, then saturate the 2-bit one
        in_valid = 1'b0; cnt_clr = 1'b1;
        step();
        check("clr_carry_cnt", 32'(carry_cnt), 32'd0);
        check("clr_carry_cnt2", 32'(carry_cnt2), 32'd0);
        cnt_clr = 1'b0; in_valid = 1'b1; {A, B, Ci} = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat_cnt2_%0d", i), 32'(carry_cnt2), 32'(sat_exp[i]));
            check($sformatf("wide_cnt_%0d", i), 32'(carry_cnt), 32'(i + 1));
            check($sformatf("b2b_out_valid_%0d", i), 32'(out_valid), 32'd1);
        end

        // Clear beats a same-cycle carry increment
        cnt_clr = 1'b1;
        step();
        check("clr_vs_inc_cnt", 32'(carry_cnt), 32'd0);
        check("clr_vs_inc_cnt2", 32'(carry_cnt2), 32'd0);
        cnt_clr = 1'b0;
        step();
        check("pre_rst_cnt", 32'(carry_cnt), 32'd1);
        check("pre_rst_Co_r", 32'(Co_r), 32'd1);

        // Reset beats a pending valid carry; combinational path unaffected
        rst = 1'b1;
        step();
        check("rstpri_out_valid", 32'(out_valid), 32'd0);
        check("rstpri_carry_cnt", 32'(carry_cnt), 32'd0);
        check("rstpri_S_r", 32'(S_r), 32'd0);
        check("rstpri_Co_r", 32'(Co_r), 32'd0);
        check("rstpri_S", 32'(S), 32'd1);
        check("rstpri_Co", 32'(Co), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
